bpt_update_ctrl: RTL and testbench
==================================

# bpt_update_ctrl

Branch-predictor-table update controller, between the branch resolution sources and the `bpt` modport of `bpt_if`. After reset it sweeps every table entry to weakly-not-taken. It then accepts resolved-branch updates from two requesters: the scalar resolution stage and the tensor-core control stage. It arbitrates between them round-robin and queues the accepted updates. It drains the queue to the predictor's `pc_res`/`taken_res`/`enable_res` inputs one update per cycle and keeps update and mispredict statistics from `pred_correct`.

## Interface
Parameters:
- `DEPTH`, 4: update queue depth; power of 2, ≥2.
- `IDX_W`, 6: predictor index width; the table holds 2^IDX_W entries.

Ports:
- `CLK`  in  1  clock, all state on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  2  per-requester update valid (bit 0 = scalar, bit 1 = tensor).
- `req_pc`  in  2×32  per-requester branch PC (`word_t`).
- `req_taken`  in  2  per-requester resolved direction.
- `req_ready`  out  2  per-requester accept; a transfer occurs when valid&ready.
- `flush`  in  1  discard all queued updates.
- `re_init`  in  1  restart the table sweep.
- `clr_stats`  in  1  zero both counters.
- `pc_res`  out  32  to bpt, head PC.
- `taken_res`  out  1  to bpt, head direction.
- `enable_res`  out  1  to bpt, update strobe.
- `pred_correct`  in  1  from bpt, valid in the cycle `enable_res`=1.
- `init_en`  out  1  to bpt, entry-initialise strobe.
- `init_idx`  out  IDX_W  to bpt, entry being initialised.
- `busy`  out  1  high in INIT or when the queue is non-empty.
- `upd_cnt`  out  16  saturating count of issued updates.
- `miss_cnt`  out  16  saturating count of issued updates with `pred_correct`=0.

## Operation
- The FSM has two states, INIT and RUN. Reset state is INIT with the sweep counter at 0.
- INIT:
  - `init_en`=1 and `init_idx`=counter.
  - The counter increments by 1 each cycle.
  - On the cycle `init_idx`=2^IDX_W−1, the next state is RUN.
  - `req_ready`=0 and `enable_res`=0.
  - `re_init` is ignored.
- RUN, `re_init`=1:
  - The queue is emptied.
  - The counter is set to 0 and the next state is INIT.
  - No pop issues that cycle and no push is accepted.
- RUN, `flush`=1 (without `re_init`):
  - Pointers and count reset to empty next cycle.
  - A push in the same cycle is dropped and `req_ready` is forced to 0.
  - `enable_res` is forced to 0 that cycle.
- Arbitration:
  - `req_ready[i]` = RUN & !full & !flush & !re_init & granted(i).
  - With only one requester valid, that requester is granted.
  - With both valid, the requester not granted last is granted.
  - The last-grant register resets to 1, so requester 0 wins the first tie.
  - The last-grant register updates only on an actual transfer.
  - At most one push per cycle.
- Queue: a circular FIFO of {pc, taken}.
  - Pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits.
  - Full is count==DEPTH. There is no bypass: `req_ready`=0 when full, even if a pop occurs that cycle.
  - Push and pop in the same cycle leave the count unchanged.
- Drain:
  - In RUN with the queue non-empty, `enable_res`=1 and `pc_res`/`taken_res` = head.
  - The head pops that cycle.
  - `pc_res`/`taken_res` are 0 whenever `enable_res`=0.
- Statistics:
  - On `enable_res`, `upd_cnt` increments; `miss_cnt` also increments if `pred_correct`=0.
  - Both counters saturate at 16'hFFFF.
  - `clr_stats` wins over a same-cycle increment: the result is 0.
  - Statistics are not cleared by `flush`/`re_init`.

## Timing
- In reset, all outputs are 0, except `init_en`=1, `init_idx`=0 and `busy`=1.
- INIT lasts exactly 2^IDX_W cycles from the first rising edge after `nRST` deasserts (64 at default).
- Push-to-issue latency:
  - An update accepted at edge N appears on `enable_res` in the cycle after edge N at the earliest.
  - Latency is minimum 1 cycle, plus queue occupancy.
- Drain throughput is 1 update per cycle; sustained acceptance is 1 per cycle once primed.
- `req_ready` is combinational from state and count only, never from `req_valid` of the same requester. The tie-break uses both valids.
- Asserting `nRST` mid-operation discards the queue and counters asynchronously and restarts INIT.

## Structure
- Shared package `datapath_pkg` gains:
  - `bpt_upd_t` (packed {`word_t` pc; logic taken}).
  - `bpt_ctrl_state_t` enum {INIT, RUN}.
  - Localparam `BPT_IDX_W` = 6.
- Natural sub-module: `bpt_upd_fifo` (parameterised DEPTH circular FIFO of `bpt_upd_t` with push/pop/flush, full/empty/count).
- The arbiter, FSM and statistics stay in the top-level block.

## Test plan
- Reset release, IDX_W=6 → `init_en` high for 64 cycles with `init_idx` 0..63; `req_ready`=0 throughout; cycle 65 has state RUN and `busy`=0.
- Requester 0 pushes pc=0x100 taken=1 → `enable_res`=1, `pc_res`=0x100, `taken_res`=1 next cycle; `upd_cnt`=1.
- Both requesters valid continuously (pc 0xA0.. and 0xB0..) → grants alternate 0,1,0,1; first issued pc=0xA0.
- DEPTH=4, queue filled while bpt outputs are observed → no 5th accept while count=4 even with a same-cycle pop; FIFO order preserved across pointer wrap.
- 3 updates issued with `pred_correct`=0,1,0 → `miss_cnt`=2, `upd_cnt`=3. `clr_stats` coincident with an issue gives both counters 0. Forcing `upd_cnt` to 0xFFFF then another issue holds it at 0xFFFF.
- Queue holding 3 entries:
  - `flush` → no `enable_res` that cycle or after; `busy`=0 next cycle.
  - Separately, `re_init` → 64-cycle sweep restarts at `init_idx`=0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath types for the branch-predictor update path.
package datapath_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t pc;
      logic  taken;
   } bpt_upd_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bpt_ctrl_state_t;

   localparam int BPT_IDX_W = 6;

endpackage

// File: rtl/bpt_upd_fifo.sv
// Circular FIFO of resolved-branch updates; pointers wrap naturally, count is one bit wider.
module bpt_upd_fifo
   import datapath_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clr,
   input  bpt_upd_t                 din,
   output bpt_upd_t                 dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   bpt_upd_t           mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers decide what is valid.
   always_ff @(posedge CLK) begin
      if (do_push && !clr) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/bpt_update_ctrl.sv
// Predictor update controller: table sweep after reset, round-robin intake of
// resolved branches, in-order drain to the predictor and update/miss statistics.
module bpt_update_ctrl
   import datapath_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = BPT_IDX_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [1:0]        req_valid,
   input  word_t [1:0]       req_pc,
   input  logic [1:0]        req_taken,
   output logic [1:0]        req_ready,
   input  logic              flush,
   input  logic              re_init,
   input  logic              clr_stats,
   output word_t             pc_res,
   output logic              taken_res,
   output logic              enable_res,
   input  logic              pred_correct,
   output logic              init_en,
   output logic [IDX_W-1:0]  init_idx,
   output logic              busy,
   output logic [15:0]       upd_cnt,
   output logic [15:0]       miss_cnt
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   bpt_ctrl_state_t   state;
   logic [IDX_W-1:0]  sweep_cnt;
   logic              last_grant;
   logic              run;
   logic              stall;
   logic              can_push;
   logic              push0;
   logic              push1;
   logic              push;
   logic              pop;
   logic              fifo_clr;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   bpt_upd_t          fifo_din;
   bpt_upd_t          head;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign run      = (state == RUN);
   assign stall    = flush | re_init;
   assign can_push = run & ~fifo_full & ~stall;

   // A requester is only held off when the other one is also asking and it won last time.
   assign req_ready[0] = can_push & ~(req_valid[1] & (last_grant == 1'b0));
   assign req_ready[1] = can_push & ~(req_valid[0] & (last_grant == 1'b1));

   assign push0    = req_valid[0] & req_ready[0];
   assign push1    = req_valid[1] & req_ready[1];
   assign push     = push0 | push1;
   assign fifo_din = push1 ? '{pc: req_pc[1], taken: req_taken[1]}
                           : '{pc: req_pc[0], taken: req_taken[0]};

   assign pop      = run & ~fifo_empty & ~stall;
   assign fifo_clr = run & stall;

   assign enable_res = pop;
   assign pc_res     = pop ? head.pc : '0;
   assign taken_res  = pop & head.taken;
   assign init_en    = ~run;
   assign init_idx   = sweep_cnt;
   assign busy       = ~run | (fifo_count != '0);

   bpt_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .nRST  (nRST),
      .push  (push),
      .pop   (pop),
      .clr   (fifo_clr),
      .din   (fifo_din),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= INIT;
         sweep_cnt  <= '0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               sweep_cnt <= sweep_cnt + IDX_W'(1);
               if (sweep_cnt == '1) state <= RUN;
            end
            RUN: begin
               if (re_init) begin
                  sweep_cnt <= '0;
                  state     <= INIT;
               end
            end
            default: state <= INIT;
         endcase
         if (push) last_grant <= push1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         upd_cnt  <= '0;
         miss_cnt <= '0;
      end else if (clr_stats) begin
         upd_cnt  <= '0;
         miss_cnt <= '0;
      end else if (enable_res) begin
         upd_cnt <= sat_inc(upd_cnt);
         if (!pred_correct) miss_cnt <= sat_inc(miss_cnt);
      end
   end

endmodule

// File: tb/tb_bpt_update_ctrl.sv
// Directed bench for bpt_update_ctrl plus a direct check of its FIFO's full/wrap behaviour.
module tb_bpt_update_ctrl;
   import datapath_pkg::*;

   logic              CLK = 1'b0;
   logic              nRST = 1'b0;
   logic [1:0]        req_valid = '0;
   logic [1:0][31:0]  req_pc = '0;
   logic [1:0]        req_taken = '0;
   logic [1:0]        req_ready;
   logic              flush = 1'b0;
   logic              re_init = 1'b0;
   logic              clr_stats = 1'b0;
   logic [31:0]       pc_res;
   logic              taken_res;
   logic              enable_res;
   logic              pred_correct = 1'b1;
   logic              init_en;
   logic [5:0]        init_idx;
   logic              busy;
   logic [15:0]       upd_cnt;
   logic [15:0]       miss_cnt;

   logic              f_push = 1'b0;
   logic              f_pop = 1'b0;
   logic              f_clr = 1'b0;
   bpt_upd_t          f_din = '0;
   bpt_upd_t          f_dout;
   logic              f_full;
   logic              f_empty;
   logic [2:0]        f_count;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   bpt_update_ctrl #(.DEPTH(4), .IDX_W(6)) dut (
      .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_pc(req_pc),
      .req_taken(req_taken), .req_ready(req_ready), .flush(flush),
      .re_init(re_init), .clr_stats(clr_stats), .pc_res(pc_res),
      .taken_res(taken_res), .enable_res(enable_res),
      .pred_correct(pred_correct), .init_en(init_en), .init_idx(init_idx),
      .busy(busy), .upd_cnt(upd_cnt), .miss_cnt(miss_cnt)
   );

   bpt_upd_fifo #(.DEPTH(4)) u_fifo (
      .CLK(CLK), .nRST(nRST), .push(f_push), .pop(f_pop), .clr(f_clr),
      .din(f_din), .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
   );

   task automatic test_reset();
      #2;
      checks++;
      if ({init_en, init_idx, busy, req_ready, enable_res, pc_res, upd_cnt, miss_cnt} !==
          {1'b1, 6'd0, 1'b1, 2'b00, 1'b0, 32'd0, 16'd0, 16'd0}) begin
         errors++;
         $display("FAIL reset_outputs: init_en=%b idx=%0d busy=%b rdy=%b en=%b pc=%h upd=%0d miss=%0d",
                  init_en, init_idx, busy, req_ready, enable_res, pc_res, upd_cnt, miss_cnt);
      end
      @(negedge CLK);
      nRST = 1'b1;
      req_valid = 2'b11;
      for (int k = 0; k < 64; k++) begin
         if (k > 0) @(negedge CLK);
         #1;
         checks++;
         if (init_en !== 1'b1 || init_idx !== 6'(k) || req_ready !== 2'b00 || enable_res !== 1'b0) begin
            errors++;
            $display("FAIL sweep_%0d: init_en=%b idx=%0d rdy=%b en=%b, expected init_en=1 idx=%0d rdy=00 en=0",
                     k, init_en, init_idx, req_ready, enable_res, k);
         end
      end
      @(negedge CLK);
      req_valid = 2'b00;
      #1;
      checks++;
      if (init_en !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b11) begin
         errors++;
         $display("FAIL run_entry: init_en=%b busy=%b rdy=%b, expected 0 0 11", init_en, busy, req_ready);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      logic [31:0] pc0 [4]     = '{32'hA0, 32'hA4, 32'hA4, 32'hA8};
      logic [31:0] pc1 [4]     = '{32'hB0, 32'hB0, 32'hB4, 32'hB4};
      logic [32:0] exp_out [6] = '{33'h0, {32'hA0, 1'b1}, {32'hB0, 1'b0}, {32'hA4, 1'b1},
                                   {32'hB4, 1'b0}, 33'h0};
      req_taken = 2'b01;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         if (c < 4) begin
            req_valid = 2'b11;
            req_pc[0] = pc0[c];
            req_pc[1] = pc1[c];
         end else begin
            req_valid = 2'b00;
         end
         #1;
         if (c < 4) begin
            checks++;
            if (req_ready !== exp_rdy[c]) begin
               errors++;
               $display("FAIL rr_grant_%0d: req_ready=%b expected %b", c, req_ready, exp_rdy[c]);
            end
         end
         checks++;
         if ({pc_res, taken_res} !== exp_out[c] || enable_res !== (c >= 1 && c <= 4)) begin
            errors++;
            $display("FAIL rr_issue_%0d: en=%b pc=%h taken=%b expected pc=%h taken=%b",
                     c, enable_res, pc_res, taken_res, exp_out[c][32:1], exp_out[c][0]);
         end
      end
   endtask

   task automatic test_single();
      @(negedge CLK);
      clr_stats = 1'b1;
      @(negedge CLK);
      clr_stats = 1'b0;
      req_valid = 2'b01;
      req_pc[0] = 32'h100;
      req_taken = 2'b01;
      #1;
      checks++;
      if (req_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: req_ready[0]=%b expected 1", req_ready[0]);
      end
      @(negedge CLK);
      req_valid = 2'b00;
      pred_correct = 1'b1;
      #1;
      checks++;
      if (enable_res !== 1'b1 || pc_res !== 32'h100 || taken_res !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_issue: en=%b pc=%h taken=%b busy=%b expected 1 100 1 1",
                  enable_res, pc_res, taken_res, busy);
      end
      @(negedge CLK);
      #1;
      checks++;
      if (upd_cnt !== 16'd1 || miss_cnt !== 16'd0 || enable_res !== 1'b0 || pc_res !== 32'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_after: upd=%0d miss=%0d en=%b pc=%h busy=%b expected 1 0 0 0 0",
                  upd_cnt, miss_cnt, enable_res, pc_res, busy);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (i < 6) begin
            req_valid = 2'b01;
            req_pc[0] = 32'h200 + 32'(i * 4);
            req_taken[0] = i[0];
         end else begin
            req_valid = 2'b00;
         end
         #1;
         if (i < 6) begin
            checks++;
            if (req_ready[0] !== 1'b1) begin
               errors++;
               $display("FAIL wrap_ready_%0d: req_ready[0]=%b expected 1", i, req_ready[0]);
            end
         end
         if (i >= 1 && i <= 6) begin
            checks++;
            if (enable_res !== 1'b1 || pc_res !== 32'h200 + 32'((i - 1) * 4) || taken_res !== (i[0] == 1'b0)) begin
               errors++;
               $display("FAIL wrap_issue_%0d: en=%b pc=%h taken=%b expected pc=%h", i, enable_res,
                        pc_res, taken_res, 32'h200 + 32'((i - 1) * 4));
            end
         end
      end
      checks++;
      if (enable_res !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap_idle: en=%b busy=%b expected 0 0", enable_res, busy);
      end
   endtask

   task automatic test_stats();
      @(negedge CLK);
      clr_stats = 1'b1;
      req_valid = 2'b01;
      req_pc[0] = 32'h300;
      @(negedge CLK);
      clr_stats = 1'b0;
      req_pc[0] = 32'h304;
      pred_correct = 1'b0;
      @(negedge CLK);
      req_pc[0] = 32'h308;
      pred_correct = 1'b1;
      @(negedge CLK);
      req_valid = 2'b00;
      pred_correct = 1'b0;
      @(negedge CLK);
      pred_correct = 1'b1;
      #1;
      checks++;
      if (upd_cnt !== 16'd3 || miss_cnt !== 16'd2) begin
         errors++;
         $display("FAIL stats_count: upd=%0d miss=%0d expected 3 2", upd_cnt, miss_cnt);
      end
      req_valid = 2'b01;
      req_pc[0] = 32'h30C;
      @(negedge CLK);
      req_valid = 2'b00;
      clr_stats = 1'b1;
      pred_correct = 1'b0;
      #1;
      checks++;
      if (enable_res !== 1'b1) begin
         errors++;
         $display("FAIL stats_clr_issue: en=%b expected 1", enable_res);
      end
      @(negedge CLK);
      clr_stats = 1'b0;
      pred_correct = 1'b1;
      #1;
      checks++;
      if (upd_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
         errors++;
         $display("FAIL stats_clr_wins: upd=%0d miss=%0d expected 0 0", upd_cnt, miss_cnt);
      end
   endtask

   task automatic test_flush();
      @(negedge CLK);
      req_valid = 2'b01;
      req_pc[0] = 32'h400;
      @(negedge CLK);
      req_pc[0] = 32'h404;
      flush = 1'b1;
      #1;
      checks++;
      if (enable_res !== 1'b0 || pc_res !== 32'd0 || req_ready !== 2'b00) begin
         errors++;
         $display("FAIL flush_cycle: en=%b pc=%h rdy=%b expected 0 0 00", enable_res, pc_res, req_ready);
      end
      @(negedge CLK);
      flush = 1'b0;
      req_valid = 2'b00;
      #1;
      checks++;
      if (enable_res !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_after: en=%b busy=%b expected 0 0", enable_res, busy);
      end
   endtask

   task automatic test_reinit();
      @(negedge CLK);
      req_valid = 2'b01;
      req_pc[0] = 32'h500;
      @(negedge CLK);
      req_valid = 2'b10;
      req_pc[1] = 32'h504;
      re_init = 1'b1;
      #1;
      checks++;
      if (enable_res !== 1'b0 || req_ready !== 2'b00) begin
         errors++;
         $display("FAIL reinit_cycle: en=%b rdy=%b expected 0 00", enable_res, req_ready);
      end
      for (int k = 0; k < 64; k++) begin
         @(negedge CLK);
         re_init = 1'b0;
         #1;
         checks++;
         if (init_en !== 1'b1 || init_idx !== 6'(k) || enable_res !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL resweep_%0d: init_en=%b idx=%0d en=%b rdy=%b expected 1 %0d 0 00",
                     k, init_en, init_idx, enable_res, req_ready, k);
         end
      end
      @(negedge CLK);
      req_valid = 2'b00;
      #1;
      checks++;
      if (init_en !== 1'b0 || busy !== 1'b0 || enable_res !== 1'b0) begin
         errors++;
         $display("FAIL reinit_run: init_en=%b busy=%b en=%b expected 0 0 0", init_en, busy, enable_res);
      end
   endtask

   task automatic test_fifo_full();
      logic [31:0] exp_pop [4] = '{32'd2, 32'd3, 32'd4, 32'd6};
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         f_push = 1'b1;
         f_din = '{pc: 32'(i + 1), taken: 1'b0};
      end
      @(negedge CLK);
      f_push = 1'b1;
      f_pop = 1'b1;
      f_din = '{pc: 32'd5, taken: 1'b1};
      #1;
      checks++;
      if (f_count !== 3'd4 || f_full !== 1'b1 || f_dout.pc !== 32'd1) begin
         errors++;
         $display("FAIL fifo_full: count=%0d full=%b head=%0d expected 4 1 1", f_count, f_full, f_dout.pc);
      end
      @(negedge CLK);
      f_pop = 1'b0;
      f_din = '{pc: 32'd6, taken: 1'b1};
      #1;
      checks++;
      if (f_count !== 3'd3 || f_full !== 1'b0 || f_dout.pc !== 32'd2) begin
         errors++;
         $display("FAIL fifo_no_bypass: count=%0d full=%b head=%0d expected 3 0 2", f_count, f_full, f_dout.pc);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         f_push = 1'b0;
         f_pop = 1'b1;
         #1;
         checks++;
         if (f_dout.pc !== exp_pop[i]) begin
            errors++;
            $display("FAIL fifo_order_%0d: head=%0d expected %0d", i, f_dout.pc, exp_pop[i]);
         end
      end
      @(negedge CLK);
      f_pop = 1'b0;
      #1;
      checks++;
      if (f_empty !== 1'b1 || f_count !== 3'd0) begin
         errors++;
         $display("FAIL fifo_empty: empty=%b count=%0d expected 1 0", f_empty, f_count);
      end
   endtask

   task automatic test_saturate();
      @(negedge CLK);
      clr_stats = 1'b1;
      @(negedge CLK);
      clr_stats = 1'b0;
      req_valid = 2'b01;
      pred_correct = 1'b0;
      repeat (65540) @(negedge CLK);
      req_valid = 2'b00;
      repeat (2) @(negedge CLK);
      pred_correct = 1'b1;
      #1;
      checks++;
      if (upd_cnt !== 16'hFFFF || miss_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL saturate: upd=%h miss=%h expected ffff ffff", upd_cnt, miss_cnt);
      end
   endtask

   task automatic test_async_reset();
      @(negedge CLK);
      req_valid = 2'b01;
      req_pc[0] = 32'h600;
      @(negedge CLK);
      req_valid = 2'b00;
      #2;
      nRST = 1'b0;
      #1;
      checks++;
      if (init_en !== 1'b1 || init_idx !== 6'd0 || busy !== 1'b1 || enable_res !== 1'b0 ||
          req_ready !== 2'b00 || upd_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
         errors++;
         $display("FAIL async_reset: init_en=%b idx=%0d busy=%b en=%b rdy=%b upd=%0d miss=%0d",
                  init_en, init_idx, busy, enable_res, req_ready, upd_cnt, miss_cnt);
      end
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_wrap();
      test_stats();
      test_flush();
      test_reinit();
      test_fifo_full();
      test_saturate();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
